// File: rtl/big_core_vga_mem_arb_pkg.sv
// Shared types and constants for the VGA frame-buffer port-A arbiter and fill engine.
package big_core_vga_pkg;
  localparam int VGA_MEM_WORDS     = 9600;
  localparam int VGA_WORDS_PER_ROW = 80;

  typedef logic [13:0] t_vga_word_addr;

  typedef enum logic [1:0] {
    VGA_FILL_IDLE = 2'd0,
    VGA_FILL_RUN  = 2'd1,
    VGA_FILL_DONE = 2'd2
  } t_vga_fill_st;
endpackage

// File: rtl/big_core_vga_mem_arb_if.sv
// Core request/response, fill configuration and port-A memory signals of the VGA arbiter.
interface big_core_vga_mem_arb_if;
  import big_core_vga_pkg::*;

  logic           CoreReqValid;
  logic           CoreReqWr;
  t_vga_word_addr CoreReqAddr;
  logic [31:0]    CoreReqData;
  logic [3:0]     CoreReqByteEn;
  logic           CoreReady;
  logic           CoreRspValid;
  logic [31:0]    CoreRspData;

  logic           CfgStart;
  logic           CfgAbort;
  t_vga_word_addr CfgStartWord;
  logic [13:0]    CfgNumWords;
  logic [31:0]    CfgPattern;
  logic           CfgAlt;
  logic           FillBusy;
  logic           FillDone;
  logic           FillAborted;

  t_vga_word_addr MemAddr;
  logic [31:0]    MemData;
  logic [3:0]     MemByteEn;
  logic           MemWrEn;
  logic           MemRdEn;
  logic [31:0]    MemQ;

  modport slave (
    input  CoreReqValid, CoreReqWr, CoreReqAddr, CoreReqData, CoreReqByteEn,
    output CoreReady, CoreRspValid, CoreRspData,
    input  CfgStart, CfgAbort, CfgStartWord, CfgNumWords, CfgPattern, CfgAlt,
    output FillBusy, FillDone, FillAborted,
    output MemAddr, MemData, MemByteEn, MemWrEn, MemRdEn,
    input  MemQ
  );

  modport master (
    output CoreReqValid, CoreReqWr, CoreReqAddr, CoreReqData, CoreReqByteEn,
    input  CoreReady, CoreRspValid, CoreRspData,
    output CfgStart, CfgAbort, CfgStartWord, CfgNumWords, CfgPattern, CfgAlt,
    input  FillBusy, FillDone, FillAborted,
    input  MemAddr, MemData, MemByteEn, MemWrEn, MemRdEn,
    output MemQ
  );
endinterface

// File: rtl/big_core_vga_fill_addr_gen.sv
// Fill range tracker: normalised start address with wrap, clamped remaining count, index parity.
module big_core_vga_fill_addr_gen
  import big_core_vga_pkg::*;
#(
  parameter int MEM_WORDS = VGA_MEM_WORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  t_vga_word_addr i_start_word,
  input  logic [13:0]    i_num_words,
  input  logic           i_step,
  output t_vga_word_addr o_cur_addr,
  output logic           o_last,
  output logic           o_idx_odd
);
  localparam logic [13:0] W_WORDS = 14'(MEM_WORDS);
  localparam logic [13:0] W_LAST  = 14'(MEM_WORDS - 1);

  t_vga_word_addr r_cur;
  logic [13:0]    r_remain;
  logic           r_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur    <= '0;
      r_remain <= '0;
      r_odd    <= 1'b0;
    end else if (i_load) begin
      r_cur    <= (i_start_word >= W_WORDS) ? i_start_word - W_WORDS : i_start_word;
      r_remain <= (i_num_words > W_WORDS) ? W_WORDS : i_num_words;
      r_odd    <= 1'b0;
    end else if (i_step) begin
      r_cur    <= (r_cur == W_LAST) ? '0 : r_cur + 14'd1;
      r_remain <= r_remain - 14'd1;
      r_odd    <= ~r_odd;
    end
  end

  assign o_cur_addr = r_cur;
  assign o_last     = (r_remain == 14'd1);
  assign o_idx_odd  = r_odd;
endmodule

// File: rtl/big_core_vga_mem_arb.sv
// VGA memory port-A arbiter: core load/store vs. hardware fill engine.
// Optional fill anti-starvation slot enabled by defining VGA_ARB_FAIR_EN.
module big_core_vga_mem_arb
  import big_core_vga_pkg::*;
#(
  parameter int MEM_WORDS = VGA_MEM_WORDS
`ifdef VGA_ARB_FAIR_EN
  , parameter int FAIR_THRESH = 16
`endif
) (
  input  logic                  CLK_50,
  input  logic                  Reset_N,
  big_core_vga_mem_arb_if.slave bus
);
  localparam logic [1:0] ST_IDLE = VGA_FILL_IDLE;
  localparam logic [1:0] ST_RUN  = VGA_FILL_RUN;
  localparam logic [1:0] ST_DONE = VGA_FILL_DONE;

  logic [1:0]     r_rst_sync;
  logic [1:0]     r_state;
  logic [31:0]    r_pattern;
  logic           r_alt;
  logic           r_aborted;
  logic           r_rsp_vld;
  logic           w_rst_n;
  logic           w_start;
  logic           w_abort;
  logic           w_forced;
  logic           w_core_ready;
  logic           w_grant_core;
  logic           w_fill_wr;
  logic           w_last;
  logic           w_idx_odd;
  t_vga_word_addr w_cur_addr;
  logic [31:0]    w_fill_data;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge CLK_50 or negedge Reset_N) begin
    if (!Reset_N) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_start      = bus.CfgStart & (r_state == ST_IDLE);
  assign w_abort      = bus.CfgAbort & (r_state == ST_RUN);
  assign w_grant_core = w_rst_n & bus.CoreReqValid & w_core_ready;
  assign w_fill_wr    = (r_state == ST_RUN) & ~w_abort & (~bus.CoreReqValid | w_forced);
  assign w_fill_data  = (r_alt & w_idx_odd) ? ~r_pattern : r_pattern;

`ifdef VGA_ARB_FAIR_EN
  logic [4:0] r_fair_cnt;

  always_ff @(posedge CLK_50 or negedge w_rst_n) begin
    if (!w_rst_n)                          r_fair_cnt <= '0;
    else if (r_state != ST_RUN || w_fill_wr) r_fair_cnt <= '0;
    else if (bus.CoreReqValid && !w_abort)   r_fair_cnt <= r_fair_cnt + 5'd1;
  end

  assign w_forced     = (r_state == ST_RUN) & (r_fair_cnt == 5'(FAIR_THRESH)) & ~bus.CfgAbort;
  assign w_core_ready = ~w_forced;
`else
  assign w_forced     = 1'b0;
  assign w_core_ready = 1'b1;
`endif

  big_core_vga_fill_addr_gen #(
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_gen (
    .clk          (CLK_50),
    .rst_n        (w_rst_n),
    .i_load       (w_start),
    .i_start_word (bus.CfgStartWord),
    .i_num_words  (bus.CfgNumWords),
    .i_step       (w_fill_wr),
    .o_cur_addr   (w_cur_addr),
    .o_last       (w_last),
    .o_idx_odd    (w_idx_odd)
  );

  always_ff @(posedge CLK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_pattern <= '0;
      r_alt     <= 1'b0;
      r_aborted <= 1'b0;
      r_rsp_vld <= 1'b0;
    end else begin
      r_rsp_vld <= w_grant_core & ~bus.CoreReqWr;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_pattern <= bus.CfgPattern;
          r_alt     <= bus.CfgAlt;
          r_aborted <= 1'b0;
          r_state   <= (bus.CfgNumWords == 14'd0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (w_abort) begin
            r_aborted <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_fill_wr && w_last) begin
            r_state   <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.MemAddr   = '0;
    bus.MemData   = '0;
    bus.MemByteEn = '0;
    bus.MemWrEn   = 1'b0;
    bus.MemRdEn   = 1'b0;
    if (w_grant_core) begin
      bus.MemAddr   = bus.CoreReqAddr;
      bus.MemData   = bus.CoreReqData;
      bus.MemByteEn = bus.CoreReqByteEn;
      bus.MemWrEn   = bus.CoreReqWr;
      bus.MemRdEn   = ~bus.CoreReqWr;
    end else if (w_fill_wr) begin
      bus.MemAddr   = w_cur_addr;
      bus.MemData   = w_fill_data;
      bus.MemByteEn = 4'hF;
      bus.MemWrEn   = 1'b1;
    end
  end

  assign bus.CoreReady    = w_core_ready;
  assign bus.CoreRspValid = r_rsp_vld;
  assign bus.CoreRspData  = r_rsp_vld ? bus.MemQ : 32'd0;
  assign bus.FillBusy     = (r_state == ST_RUN) | (r_state == ST_DONE);
  assign bus.FillDone     = (r_state == ST_DONE);
  assign bus.FillAborted  = r_aborted;
endmodule

// File: doc/big_core_vga_mem_arb.md
Name: big_core_vga_mem_arb

Overview:
- Owns write/read port A of the VGA frame-buffer memory (1 bit/pixel, 80 words per 4-line text row, 9600 words).
- Shares port A between two requesters: the core load/store path, and a built-in hardware fill engine that clears or patterns a word range.
- The fill engine lets software blank the screen or a region without 9600 store instructions.
- Sits between the core memory stage and the VGA memory; the pixel-read port B is untouched.

Parameters:
- MEM_WORDS, 9600, number of 32-bit words in the VGA memory; address wrap modulus.
- FAIR_THRESH, 16, consecutive denied fill cycles before one forced fill slot (used only with the optional feature).

Ports:
- CLK_50  in  1  single clock.
- Reset_N  in  1  asynchronous, active-low reset.
- CoreReqValid  in  1  core access request this cycle.
- CoreReqWr  in  1  1=write, 0=read.
- CoreReqAddr  in  14  word address.
- CoreReqData  in  32  write data.
- CoreReqByteEn  in  4  write byte enables.
- CoreReady  out  1  core request accepted this cycle.
- CoreRspValid  out  1  read data valid.
- CoreRspData  out  32  read data.
- CfgStart  in  1  one-cycle pulse that launches a fill.
- CfgAbort  in  1  stop the running fill.
- CfgStartWord  in  14  first word of the fill.
- CfgNumWords  in  14  word count.
- CfgPattern  in  32  fill word.
- CfgAlt  in  1  when 1, odd fill words use ~CfgPattern.
- FillBusy  out  1  engine active.
- FillDone  out  1  one-cycle completion pulse.
- FillAborted  out  1  sticky; set by abort, cleared by next CfgStart.
- MemAddr  out  14  port A address.
- MemData  out  32  port A write data.
- MemByteEn  out  4  port A byte enables.
- MemWrEn  out  1  port A write enable.
- MemRdEn  out  1  port A read enable.
- MemQ  in  32  port A read data, 1-cycle latency.

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE; all counters 0.
- Outputs at reset: FillBusy, FillDone, FillAborted, CoreRspValid, MemWrEn, MemRdEn = 0; CoreRspData = 0; CoreReady = 1.
- Port A outputs are combinational from the grant. Exactly one requester drives port A per cycle.
- Priority: a core request always wins, except for a forced fill slot (optional feature only).
- Read response:
  - CoreRspValid = registered (grant_core & ~CoreReqWr); CoreRspData = MemQ in that cycle.
  - Latency is exactly 1 cycle.
- FSM states:
  - IDLE: on CfgStart, latch StartWord, NumWords, Pattern and Alt; clear the word index; clear FillAborted.
    - NumWords = 0 -> go to DONE.
    - Otherwise -> go to FILL.
  - FILL: in each cycle without a core request (or in a forced slot), write one word.
    - Write data: MemWrEn=1, MemByteEn=4'hF, MemAddr=CurAddr, MemData=Pattern, or ~Pattern when Alt=1 and the index is odd.
    - After each write: CurAddr increments, wrapping MEM_WORDS-1 -> 0; Remaining decrements.
    - The last write (Remaining==1) -> go to DONE.
  - DONE: FillDone=1 for one cycle -> IDLE.
- FillBusy = 1 in FILL and DONE.
- CfgStart while FillBusy is ignored; no relatch.
- CfgAbort in FILL: no write that cycle, FillAborted=1, go to DONE.
- CfgAbort in IDLE has no effect. If CfgStart and CfgAbort arrive together in IDLE, the start wins.
- CfgStartWord >= MEM_WORDS is reduced: subtract MEM_WORDS once at latch.
- CfgNumWords > MEM_WORDS is clamped to MEM_WORDS.
- Core write to the same address in the same cycle as a fill write is impossible, because only one grant exists per cycle.
- Reset asserted mid-fill: the fill is abandoned immediately, with no FillDone.

Optional Feature:
- Macro VGA_ARB_FAIR_EN.
- Defined:
  - A 5-bit counter counts FILL cycles where the fill was denied by the core; it clears on any fill write.
  - When the count reaches FAIR_THRESH, the next cycle is a forced fill slot: the fill writes and CoreReady=0. The core must hold its request, which is then accepted the following cycle.
  - CoreRspValid is never generated for an unaccepted read.
- Not defined: CoreReady is tied to 1; the fill can starve indefinitely under continuous core traffic.

Decomposition:
- Package big_core_vga_pkg contains:
  - VGA_MEM_WORDS=9600 and VGA_WORDS_PER_ROW=80.
  - typedef t_vga_word_addr (logic[13:0]).
  - typedef enum t_vga_fill_st {VGA_FILL_IDLE, VGA_FILL_RUN, VGA_FILL_DONE}.
- One sub-module, big_core_vga_fill_addr_gen, holds the latched range, wrapping address counter and remaining counter. The arbiter and FSM stay in the top.

Test Plan:
- Idle core, CfgStart, StartWord=0, NumWords=9600, Pattern=0 -> 9600 consecutive writes, addresses 0..9599; FillDone asserted 9601 cycles after the start.
- StartWord=9598, NumWords=4, Pattern=32'hA5A5_A5A5, Alt=1:
  - Writes to 9598, 9599, 0, 1.
  - Data A5A5A5A5, 5A5A5A5A, A5A5A5A5, 5A5A5A5A.
- Fill of 8 words while the core reads addr 100 for 3 cycles:
  - Core is granted each of those cycles; CoreRspValid follows 1 cycle later with MemQ.
  - The fill stalls, then completes; total 11 cycles to DONE.
- NumWords=0 -> no MemWrEn; FillDone 1 cycle after the start. A second CfgStart during a busy fill is ignored (the range is unchanged).
- CfgAbort after the 3rd write of a 10-word fill -> exactly 3 writes, FillAborted=1, one FillDone pulse. The next CfgStart clears FillAborted.
- With VGA_ARB_FAIR_EN and continuous core writes during a fill:
  - After 16 denied cycles, CoreReady=0 for 1 cycle and one fill write occurs.
  - The held core write is accepted the next cycle.
